td4_sequencer: RTL and testbench
================================

TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 The block SHALL have one clock: clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have reset n_reset, input, 1, asynchronous active-low; it clears all state immediately on assertion.
REQ-003 The block SHALL have instr, input, 8, current program word: opcode [7:4], immediate [3:0].
REQ-004 The block SHALL have pc, input, 4, the datapath program counter, used only for halt detection.
REQ-005 The block SHALL have cf, input, 1, the datapath carry flag.
REQ-006 The block SHALL have run, input, 1, level; continuous execution while high.
REQ-007 The block SHALL have step, input, 1, level; each rising edge requests one instruction.
REQ-008 The block SHALL have halt_clr, input, 1, a one-cycle pulse that leaves HALT.
REQ-009 The block SHALL have select_a and select_b, output, 1 each; the datapath source is {select_b,select_a}: 00=A, 01=B, 10=IN, 11=zero.
REQ-010 The block SHALL have load0, load1, load2 and load3, output, 1 each, load enables for A, B, OUT and PC.
REQ-011 The block SHALL have dp_en, output, 1, a one-cycle datapath commit strobe.
REQ-012 The block SHALL have busy, output, 1, high in FETCH, DECODE and EXEC.
REQ-013 The block SHALL have halted, output, 1, high in HALT.
REQ-014 The block SHALL have instr_count, output, 8, the count of executed instructions.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and HALT, all with registered outputs.
REQ-016 IDLE SHALL go to FETCH when run=1 or a step rising edge is detected; run SHALL win over step when both occur together.
REQ-017 FETCH SHALL latch instr and pc into internal registers, then go to DECODE.
REQ-018 DECODE SHALL compute select and load values from the latched opcode, sample cf, then go to EXEC.
REQ-019 EXEC SHALL drive dp_en=1 with the decoded selects and loads for exactly one cycle.
REQ-020 Outside EXEC, all loads and dp_en SHALL be 0, and the selects SHALL be 11.
REQ-021 After EXEC, the FSM SHALL go to HALT if halt was detected; otherwise to FETCH if run=1; otherwise to IDLE.
REQ-022 Latency SHALL be 3 cycles per instruction from FETCH entry to the dp_en pulse; back-to-back run throughput SHALL be 1 instruction per 3 cycles.
REQ-023 The decode table SHALL be:
- 0000 ADD A,Im: A, load0
- 0101 ADD B,Im: B, load1
- 0001 MOV A,B: B, load0
- 0100 MOV B,A: A, load1
- 0011 MOV A,Im: zero, load0
- 0111 MOV B,Im: zero, load1
- 0010 IN A: IN, load0
- 0110 IN B: IN, load1
- 1001 OUT B: B, load2
- 1011 OUT Im: zero, load2
- 1111 JMP: zero, load3=1
- 1110 JNC: zero, load3 = NOT the cf sampled in DECODE
REQ-024 Any other opcode SHALL be a NOP: dp_en still pulses, all loads are 0, and the selects are 11.
REQ-025 Halt SHALL be detected when the latched opcode is 1111 and the latched immediate equals the latched pc.
REQ-026 JNC with cf=1 SHALL NOT be a halt.
REQ-027 HALT SHALL be sticky and ignore run and step; halt_clr SHALL move it to IDLE on the next edge.
REQ-028 Step edge detection SHALL use a registered copy of step; an edge arriving while busy SHALL be discarded and not queued.
REQ-029 instr_count SHALL increment on every dp_en pulse, including NOPs, and saturate at 255.
REQ-030 Dropping run mid-instruction SHALL complete the current instruction and then go to IDLE.

Reset
REQ-031 On n_reset=0, the block SHALL immediately force: state IDLE; selects 11; all loads, dp_en, busy and halted 0; instr_count 0; step history 0.
REQ-032 Reset mid-instruction SHALL abort the instruction with no dp_en pulse.
REQ-033 After release, the block SHALL stay in IDLE until run or a step edge.

Verification
REQ-034 Bench scenario, step with ADD: instr=0x03, one step pulse -> dp_en high exactly at cycle 3 after the edge with sel=00 and load0=1; then IDLE; instr_count=1.
REQ-035 Bench scenario, JNC: JNC 0x5 with cf=0 -> load3=1; with cf=1 -> load3=0, sel=11, no halt.
REQ-036 Bench scenario, halt: run=1, pc=7, instr=0xF7 -> halted=1 after EXEC, instr_count frozen; halt_clr -> IDLE.
REQ-037 Bench scenario, step while busy: a step edge during DECODE is ignored -> exactly one dp_en.
REQ-038 Bench scenario, reset during DECODE: no dp_en, all outputs at reset values; run held high -> restart at FETCH.
REQ-039 Bench scenario, saturation: 260 NOPs under run -> instr_count=255.

Source files
------------

// File: rtl/td4_sequencer.sv
// td4_sequencer: fetch/decode/exec control FSM for the TD4 datapath with run/step/halt control.
module td4_sequencer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] instr,
  input  logic [3:0] pc,
  input  logic       cf,
  input  logic       run,
  input  logic       step,
  input  logic       halt_clr,
  output logic       select_a,
  output logic       select_b,
  output logic       load0,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic       dp_en,
  output logic       busy,
  output logic       halted,
  output logic [7:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  state_t state, nxt;
  logic step_q;
  logic [7:0] ir;
  logic [3:0] pc_q;
  logic [5:0] dec;
  logic halt_det;
  assign halt_det = ir[7:4] == 4'hf && ir[3:0] == pc_q;
  // dec = {select_b, select_a, load3, load2, load1, load0}
  always_comb begin
    case (ir[7:4])
      4'b0000: dec = 6'b00_0001;
      4'b0101: dec = 6'b01_0010;
      4'b0001: dec = 6'b01_0001;
      4'b0100: dec = 6'b00_0010;
      4'b0011: dec = 6'b11_0001;
      4'b0111: dec = 6'b11_0010;
      4'b0010: dec = 6'b10_0001;
      4'b0110: dec = 6'b10_0010;
      4'b1001: dec = 6'b01_0100;
      4'b1011: dec = 6'b11_0100;
      4'b1111: dec = 6'b11_1000;
      4'b1110: dec = {3'b11_0 | {2'b00, ~cf}, 3'b000};
      default: dec = 6'b11_0000;
    endcase
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (run || (step && !step_q)) ? FETCH : IDLE;
      FETCH:   nxt = DECODE;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = halt_det ? HALT : run ? FETCH : IDLE;
      HALT:    nxt = halt_clr ? IDLE : HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      step_q <= 1'b0;
      ir <= '0;
      pc_q <= '0;
      {select_b, select_a, load3, load2, load1, load0} <= 6'b11_0000;
      dp_en <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      step_q <= step;
      if (state == FETCH) begin
        ir <= instr;
        pc_q <= pc;
      end
      {select_b, select_a, load3, load2, load1, load0} <= nxt == EXEC ? dec : 6'b11_0000;
      dp_en <= nxt == EXEC;
      busy <= nxt == FETCH || nxt == DECODE || nxt == EXEC;
      halted <= nxt == HALT;
      if (dp_en && instr_count != 8'hff) instr_count <= instr_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: directed stimulus with a phase-level behavioural model checked every cycle.
module tb_td4_sequencer;
  logic clk = 0, n_reset = 0;
  logic [7:0] instr = 0;
  logic [3:0] pc = 0;
  logic cf = 0, run = 0, step = 0, halt_clr = 0;
  logic select_a, select_b, load0, load1, load2, load3, dp_en, busy, halted;
  logic [7:0] instr_count;
  int n_chk = 0, n_pass = 0, pulses = 0, p0;
  bit chk_on = 0;
  logic [16:0] mexp;
  logic [5:0] lit [16] = '{6'b000001, 6'b010001, 6'b100001, 6'b110001,
                           6'b000010, 6'b010010, 6'b100010, 6'b110010,
                           6'b110000, 6'b010100, 6'b110000, 6'b110100,
                           6'b110000, 6'b110000, 6'b111000, 6'b111000};

  always #5 clk = ~clk;

  td4_sequencer dut (
    .clk(clk), .n_reset(n_reset), .instr(instr), .pc(pc), .cf(cf), .run(run),
    .step(step), .halt_clr(halt_clr), .select_a(select_a), .select_b(select_b),
    .load0(load0), .load1(load1), .load2(load2), .load3(load3), .dp_en(dp_en),
    .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_pulse;
    step = 1;
    tick();
    step = 0;
  endtask

  function automatic logic [16:0] outs();
    return {select_b, select_a, load3, load2, load1, load0, dp_en, busy, halted, instr_count};
  endfunction

  // Model: ph 0=idle, 1..3=cycle within an instruction, 4=halted
  int ph = 0, mcnt = 0;
  logic [3:0] mop = 0, mim = 0, mpc = 0;
  logic mcf = 0, mstq = 0;

  function automatic logic [5:0] m_dec(input logic [3:0] op, input logic c);
    int src = 3, dst = -1;
    case (op)
      0: begin src = 0; dst = 0; end
      1: begin src = 1; dst = 0; end
      2: begin src = 2; dst = 0; end
      3: dst = 0;
      4: begin src = 0; dst = 1; end
      5: begin src = 1; dst = 1; end
      6: begin src = 2; dst = 1; end
      7: dst = 1;
      9: begin src = 1; dst = 2; end
      11: dst = 2;
      14: dst = c ? -1 : 3;
      15: dst = 3;
      default: ;
    endcase
    return {src[1:0], dst < 0 ? 4'b0000 : 4'(1 << dst)};
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ph = 0; mstq = 0; mcnt = 0;
    end else begin
      if (ph == 3 && mcnt < 255) mcnt++;
      case (ph)
        0: if (run || (step && !mstq)) ph = 1;
        1: begin mop = instr[7:4]; mim = instr[3:0]; mpc = pc; ph = 2; end
        2: begin mcf = cf; ph = 3; end
        3: ph = (mop == 15 && mim == mpc) ? 4 : run ? 1 : 0;
        4: if (halt_clr) ph = 0;
        default: ph = 0;
      endcase
      mstq = step;
    end
  end

  always @(negedge clk) begin
    if (dp_en) pulses++;
    if (chk_on) begin
      mexp = {ph == 3 ? m_dec(mop, mcf) : 6'b110000, ph == 3, ph >= 1 && ph <= 3, ph == 4, 8'(mcnt)};
      chk("cycle", 32'(outs()), 32'(mexp));
    end
  end

  initial begin
    tick(2);
    chk("reset", 32'(outs()), 32'h18000);
    n_reset = 1;
    chk_on = 1;
    tick(3);
    chk("idle_hold", 32'(busy), 0);
    instr = 8'h03;
    step_pulse();
    chk("add_fetch_dp", 32'(dp_en), 0);
    tick();
    chk("add_decode_dp", 32'(dp_en), 0);
    tick();
    chk("add_dp", 32'(dp_en), 1);
    chk("add_sel", 32'({select_b, select_a}), 0);
    chk("add_load", 32'({load3, load2, load1, load0}), 1);
    tick();
    chk("add_idle", 32'(busy), 0);
    chk("add_cnt", 32'(instr_count), 1);
    instr = 8'hE5;
    step_pulse();
    tick(2);
    chk("jnc_cf0_load3", 32'(load3), 1);
    chk("jnc_cf0_sel", 32'({select_b, select_a}), 3);
    tick();
    cf = 1;
    step_pulse();
    tick(2);
    chk("jnc_cf1_dp", 32'(dp_en), 1);
    chk("jnc_cf1_load3", 32'(load3), 0);
    chk("jnc_cf1_sel", 32'({select_b, select_a}), 3);
    tick();
    chk("jnc_cf1_nohalt", 32'(halted), 0);
    cf = 0;
    for (int op = 0; op < 16; op++) begin
      instr = {4'(op), 4'h5};
      pc = 0;
      step_pulse();
      tick(2);
      chk($sformatf("dec_%0h", op), 32'({select_b, select_a, load3, load2, load1, load0}), 32'(lit[op]));
      tick();
    end
    pc = 7;
    instr = 8'hF7;
    run = 1;
    tick(4);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_cnt", 32'(instr_count), 20);
    step = 1;
    tick(2);
    step = 0;
    tick(3);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_frozen", 32'(instr_count), 20);
    run = 0;
    halt_clr = 1;
    tick();
    halt_clr = 0;
    chk("halt_clr", 32'(halted), 0);
    tick(2);
    chk("halt_idle", 32'(busy), 0);
    instr = 8'h80;
    pc = 0;
    p0 = pulses;
    step_pulse();
    tick();
    step = 1;
    tick(6);
    step = 0;
    tick(3);
    chk("busy_step_pulses", 32'(pulses - p0), 1);
    instr = 8'h03;
    run = 1;
    p0 = pulses;
    tick(2);
    chk("rst_pre_busy", 32'(busy), 1);
    n_reset = 0;
    #1;
    chk("rst_outs", 32'(outs()), 32'h18000);
    tick(2);
    chk("rst_nodp", 32'(pulses - p0), 0);
    n_reset = 1;
    tick();
    chk("rst_fetch_busy", 32'(busy), 1);
    chk("rst_fetch_dp", 32'(dp_en), 0);
    tick(2);
    chk("rst_restart_dp", 32'(dp_en), 1);
    instr = 8'h80;
    tick(260 * 3 + 6);
    run = 0;
    tick(4);
    chk("sat_cnt", 32'(instr_count), 255);
    chk("sat_idle", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
